// File: rtl/q_sys_user_dipsw_ctrl.sv
// Avalon-MM DIP-switch controller: 2-flop sync, per-bit debounce, edge capture, maskable IRQ.
// Optional macro DIPSW_IRQ_EN: when undefined IRQMASK reads 0 and irq is tied low.
module q_sys_user_dipsw_ctrl #(
    parameter int          WIDTH     = 4,
    parameter logic [15:0] DEB_RESET = 16'd50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1, sync2, stable, edgecap, flip, ec_clr, irq_mask;
    logic [15:0]      deb_n, n_m1;
    logic [15:0]      cnt [WIDTH];
    logic [31:0]      rd_mux;

    // N=0 behaves as N=1; ">=" lets a shortened period take effect on counters already past it
    assign n_m1 = (deb_n == 16'd0) ? 16'd0 : deb_n - 16'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign flip[i] = (sync2[i] != stable[i]) && (cnt[i] >= n_m1);

        always_ff @(posedge clk) begin
            if (!reset_n)                   cnt[i] <= '0;
            else if (sync2[i] == stable[i]) cnt[i] <= '0;
            else if (flip[i])               cnt[i] <= '0;
            else                            cnt[i] <= cnt[i] + 16'd1;
        end
    end

    assign ec_clr = (write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable  <= '0;
            edgecap <= '0;
            deb_n   <= DEB_RESET;
        end else begin
            stable  <= stable ^ flip;
            // a new edge beats a same-cycle clear
            edgecap <= (edgecap & ~ec_clr) | flip;
            if (write && address == 2'd1)
                deb_n <= writedata[15:0];
        end
    end

`ifdef DIPSW_IRQ_EN
    logic irq_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_mask <= '0;
            irq_r    <= 1'b0;
        end else begin
            if (write && address == 2'd2)
                irq_mask <= writedata[WIDTH-1:0];
            irq_r <= |(edgecap & irq_mask);
        end
    end

    assign irq = irq_r;
`else
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[WIDTH-1:0] = stable;
            2'd1: rd_mux[15:0]      = deb_n;
            2'd2: rd_mux[WIDTH-1:0] = irq_mask;
            2'd3: rd_mux[WIDTH-1:0] = edgecap;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    // read only qualifies the bus; data is registered every cycle regardless
    logic unused_ok;
    assign unused_ok = &{1'b0, read, writedata[31:16]};

endmodule

// File: tb/tb_q_sys_user_dipsw_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a sample-window reference model.
module tb_q_sys_user_dipsw_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  in_port = '0;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    q_sys_user_dipsw_ctrl #(.WIDTH(4), .DEB_RESET(16'd50000)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    // reference state: registers plus the pin pipeline and history of synchronised samples
    logic [3:0]  m_stab, m_ec, m_mask;
    logic [15:0] m_n;
    logic [3:0]  pinq[$];
    logic [3:0]  hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock edge: predict, advance the model with the inputs seen at the edge, compare
    task automatic cyc();
        logic [31:0] erd;
        logic        eirq;
        logic [3:0]  setv, clr;
        int          k;
        bit          all;
        case (address)
            2'd0:    erd = {28'd0, m_stab};
            2'd1:    erd = {16'd0, m_n};
            2'd2:    erd = {28'd0, m_mask};
            default: erd = {28'd0, m_ec};
        endcase
        eirq = |(m_ec & m_mask);
        if (!reset_n) begin
            erd  = '0;
            eirq = 1'b0;
        end
        @(posedge clk);
        if (!reset_n) begin
            m_stab = '0; m_ec = '0; m_mask = '0; m_n = 16'd50000;
            pinq = '{4'h0, 4'h0};
            hist = {};
        end else begin
            hist.push_front(pinq[1]);
            if (hist.size() > 80) void'(hist.pop_back());
            k = (m_n == 16'd0) ? 1 : int'(m_n);
            setv = '0;
            // a bit flips once its last k synchronised samples all disagree with the stable value
            for (int i = 0; i < 4; i++) begin
                if (hist.size() >= k) begin
                    all = 1'b1;
                    for (int j = 0; j < k; j++)
                        if (hist[j][i] == m_stab[i]) all = 1'b0;
                    setv[i] = all;
                end
            end
            m_stab = m_stab ^ setv;
            clr = (write && address == 2'd3) ? writedata[3:0] : 4'h0;
            m_ec = (m_ec & ~clr) | setv;
            if (write && address == 2'd1) m_n = writedata[15:0];
`ifdef DIPSW_IRQ_EN
            if (write && address == 2'd2) m_mask = writedata[3:0];
`endif
            pinq.push_front(in_port);
            void'(pinq.pop_back());
        end
        #1;
        chk("readdata", readdata, erd);
        chk("irq", {31'd0, irq}, {31'd0, eirq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        cyc();
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a; read = 1'b1;
        cyc();
        read = 1'b0;
    endtask

    initial begin
        m_stab = '0; m_ec = '0; m_mask = '0; m_n = 16'd50000;
        pinq = '{4'h0, 4'h0};

        // reset and defaults
        idle(3);
        reset_n = 1'b1;
        rd(2'd0); chk("rst_data", readdata, 32'd0);
        rd(2'd1); chk("rst_deb", readdata, 32'd50000);
        rd(2'd2); chk("rst_mask", readdata, 32'd0);
        rd(2'd3); chk("rst_ec", readdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // clean change with N=4: stable updates on edge 6, readable on edge 7
        wr(2'd1, 32'd4);
        address = 2'd0;
        in_port = 4'h5;
        idle(6);
        chk("clean_early", readdata, 32'd0);
        cyc();
        chk("clean_data", readdata, 32'd5);
        rd(2'd3); chk("clean_ec", readdata, 32'd5);
        chk("clean_irq", {31'd0, irq}, 32'd0);
        wr(2'd3, 32'h5);
        rd(2'd3); chk("clear_ec", readdata, 32'd0);

        // 3-cycle glitch on bit 1 must be rejected
        in_port = 4'h7;
        idle(3);
        in_port = 4'h5;
        idle(8);
        rd(2'd0); chk("glitch_data", readdata, 32'd5);
        rd(2'd3); chk("glitch_ec", readdata, 32'd0);

`ifdef DIPSW_IRQ_EN
        wr(2'd2, 32'h2);
        address = 2'd3;
        in_port = 4'h7;
        idle(6);
        chk("irq_before", {31'd0, irq}, 32'd0);
        cyc();
        chk("irq_set", {31'd0, irq}, 32'd1);
        chk("irq_ec", readdata, 32'd2);
        wr(2'd3, 32'h0);
        rd(2'd3); chk("w0_noeffect", readdata, 32'd2);
        wr(2'd3, 32'h2);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        cyc();
        chk("irq_clear", {31'd0, irq}, 32'd0);
`else
        wr(2'd2, 32'hF);
        rd(2'd2); chk("mask_off", readdata, 32'd0);
        in_port = in_port ^ 4'hF;
        idle(8);
        rd(2'd3); chk("ec_all", readdata, 32'hF);
        chk("irq_off", {31'd0, irq}, 32'd0);
`endif
        wr(2'd3, 32'hF);

        // set/clear collision on bit 0 with N=1 (edge lands on the 3rd edge after the pin change)
        wr(2'd1, 32'd1);
        in_port[0] = ~in_port[0];
        idle(2);
        wr(2'd3, 32'h1);
        rd(2'd3); chk("collide", {31'd0, readdata[0]}, 32'd1);
        wr(2'd3, 32'hF);

        // random traffic, including debounce changes mid-count and short resets
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 5) == 0) in_port = 4'($urandom);
            else if ($urandom_range(0, 3) == 0) in_port[$urandom_range(0, 3)] ^= 1'b1;
            address = 2'($urandom);
            read = 1'($urandom);
            write = ($urandom_range(0, 5) == 0);
            writedata = $urandom;
            if (address == 2'd1) writedata[15:0] = 16'($urandom_range(0, 12));
            reset_n = ($urandom_range(0, 299) != 0);
            cyc();
            write = 1'b0;
            reset_n = 1'b1;
            if (it % 100 == 99) wr(2'd1, 32'($urandom_range(0, 6)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
